// File: rtl/output_buffer_pp.sv
// Ping-pong output feature-map buffer: pixel-wide writes into one frame bank while the
// other bank drains one element per beat in channel-planar order.
module output_buffer_pp #(
    parameter int DATA_WIDTH   = 8,
    parameter int OUT_CHANNELS = 3,
    parameter int IN_WIDTH     = 5,
    parameter int IN_HEIGHT    = 5,
    parameter     RAM_STYLE    = "auto"
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH*OUT_CHANNELS-1:0] wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic                               rd_last,
    output logic [1:0]                         buf_count
);

    localparam int P  = IN_WIDTH * IN_HEIGHT;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(P - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(OUT_CHANNELS - 1);

    if (OUT_CHANNELS < 1 || P < 2 || RAM_STYLE == "") begin : g_param_check
        $error("output_buffer_pp: invalid parameters");
    end

    (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [2][OUT_CHANNELS][P];

    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [PW-1:0] wr_pix;
    logic [CW-1:0] rd_ch;
    logic [PW-1:0] rd_pix;
    logic          wr_fire;
    logic          issue;

    assign wr_ready  = !rst && !full[wr_bank];
    assign wr_fire   = wr_valid && wr_ready;
    assign issue     = full[rd_bank] && (!rd_valid || rd_ready);
    assign buf_count = {1'b0, full[0]} + {1'b0, full[1]};

    // Storage only; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned c = 0; c < OUT_CHANNELS; c++) begin
                mem[wr_bank][CW'(c)][wr_pix] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_pix   <= '0;
            rd_ch    <= '0;
            rd_pix   <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_pix == PIX_LAST) begin
                    wr_pix        <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_pix <= wr_pix + 1'b1;
                end
            end
            // Completing and freeing always target different banks, so both bit updates stand.
            if (issue) begin
                rd_data  <= mem[rd_bank][rd_ch][rd_pix];
                rd_last  <= (rd_ch == CH_LAST) && (rd_pix == PIX_LAST);
                rd_valid <= 1'b1;
                if (rd_pix == PIX_LAST) begin
                    rd_pix <= '0;
                    if (rd_ch == CH_LAST) begin
                        rd_ch         <= '0;
                        full[rd_bank] <= 1'b0;
                        rd_bank       <= ~rd_bank;
                    end else begin
                        rd_ch <= rd_ch + 1'b1;
                    end
                end else begin
                    rd_pix <= rd_pix + 1'b1;
                end
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_buffer_pp.sv
// Directed bench for output_buffer_pp: scoreboard of planar-order frames built from the
// values the bench writes, plus hand-placed timing checks around fills and swaps.
module tb_output_buffer_pp;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int P  = W * H;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW*CH-1:0] wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             rd_last;
    logic [1:0]       buf_count;

    output_buffer_pp #(
        .DATA_WIDTH  (DW),
        .OUT_CHANNELS(CH),
        .IN_WIDTH    (W),
        .IN_HEIGHT   (H),
        .RAM_STYLE   ("auto")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_last  (rd_last),
        .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    int wr_todo = 0;
    int wpix    = 0;
    int wfr     = 0;
    int reads   = 0;

    function automatic logic [7:0] pix_val(input int f, input int c, input int p);
        return 8'((f % 2) * 100 + c * 32 + p);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, capture pre-edge handshake state, advance, score.
    task automatic step(input bit wv, input bit rr);
        logic          w_acc, r_acc, hold, pl;
        logic [DW-1:0] pd;
        logic [8:0]    e;
        wr_valid = wv && (wr_todo > 0);
        for (int c = 0; c < CH; c++) wr_data[c*DW +: DW] = pix_val(wfr, c, wpix);
        rd_ready = rr;
        w_acc = wr_valid && wr_ready;
        r_acc = rd_valid && rd_ready;
        hold  = rd_valid && !rd_ready;
        pd    = rd_data;
        pl    = rd_last;
        @(posedge clk);
        #1;
        if (w_acc) begin
            wpix++;
            if (wpix == P) begin
                for (int c = 0; c < CH; c++)
                    for (int p = 0; p < P; p++)
                        exp_q.push_back({(c == CH-1 && p == P-1), pix_val(wfr, c, p)});
                wpix = 0;
                wfr++;
                wr_todo--;
            end
        end
        if (r_acc) begin
            reads++;
            check("rd_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data", pd, e[7:0]);
                check("rd_last", pl, e[8]);
            end
        end
        if (hold) begin
            check("hold_data", rd_data, pd);
            check("hold_last", rd_last, pl);
            check("hold_valid", rd_valid, 1);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < budget) begin
            step(0, 1);
            n++;
        end
        check(tag, (exp_q.size() == 0) && !rd_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data  = DW*CH'($urandom);
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_last", rd_last, 0);
            check("rst_rd_data", rd_data, 0);
            check("rst_buf_count", buf_count, 0);
            check("rst_wr_ready", wr_ready, 0);
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("post_rst_wr_ready", wr_ready, 1);

        // Single frame, latency of first element
        wr_todo = 1;
        for (int i = 0; i < P; i++) step(1, 1);
        check("lat_before", rd_valid, 0);
        check("single_buf_count", buf_count, 1);
        step(0, 1);
        check("lat_valid", rd_valid, 1);
        check("lat_first_data", rd_data, 0);
        drain("single_drain", 200);
        check("single_empty", buf_count, 0);

        // Fill both banks with consumer stalled
        wr_todo = 2;
        for (int i = 0; i < 2*P; i++) step(1, 0);
        check("fill_buf_count", buf_count, 2);
        check("fill_wr_ready", wr_ready, 0);
        for (int i = 1; i <= CH*P - 1; i++) begin
            step(0, 1);
            if (i == CH*P - 2) check("freed_early", wr_ready, 0);
        end
        check("freed_wr_ready", wr_ready, 1);
        check("freed_buf_count", buf_count, 1);
        drain("fill_drain", 300);

        // Random valid and backpressure, 4 frames
        begin
            int n = 0;
            reads = 0;
            wr_todo = 4;
            while (!(wr_todo == 0 && wpix == 0 && exp_q.size() == 0 && !rd_valid) && n < 4000) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                n++;
            end
            check("rand_done", n < 4000, 1);
            check("rand_reads", reads, 4*CH*P);
        end

        // Concurrent write of frame 2 while frame 1 streams out
        wr_todo = 1;
        for (int i = 0; i < P; i++) step(1, 1);
        wr_todo = 1;
        for (int i = 1; i <= 2*CH*P; i++) begin
            if (i <= P) check("conc_wr_ready", wr_ready, 1);
            step(1, 1);
            check("conc_no_gap", rd_valid, 1);
        end
        drain("conc_drain", 20);

        // Reset in the middle of a read
        begin
            int n = 0;
            wr_todo = 1;
            for (int i = 0; i < P; i++) step(1, 1);
            reads = 0;
            while (reads < 10 && n < 100) begin
                step(0, 1);
                n++;
            end
            check("mid_reads", reads, 10);
            rst = 1'b1;
            wr_valid = 1'b0;
            rd_ready = 1'b1;
            @(posedge clk);
            #1;
            check("mid_rst_rd_valid", rd_valid, 0);
            check("mid_rst_buf_count", buf_count, 0);
            check("mid_rst_wr_ready", wr_ready, 0);
            exp_q.delete();
            wpix = 0;
            wr_todo = 0;
            rst = 1'b0;
            #1;
            check("mid_post_wr_ready", wr_ready, 1);
            wr_todo = 1;
            for (int i = 0; i < P; i++) step(1, 1);
            step(0, 1);
            check("mid_first_valid", rd_valid, 1);
            check("mid_first_data", rd_data, pix_val(wfr - 1, 0, 0));
            drain("mid_drain", 200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_buffer_pp.md
# output_buffer_pp

Double-buffered (ping-pong) output feature-map buffer placed between a convolution/activation stage and the downstream consumer. The write side takes one pixel per beat, carrying all OUT_CHANNELS values. The read side streams the stored frame one element per beat in channel-planar order, with valid/ready handshakes on both sides. Two frame banks let the producer fill one frame while the consumer drains the other.

## Interface
- DATA_WIDTH, 8, bits per element
- OUT_CHANNELS, 3, channels per pixel; must be ≥ 1
- IN_WIDTH, 5, frame width in pixels
- IN_HEIGHT, 5, frame height in pixels; IN_WIDTH*IN_HEIGHT must be ≥ 2
- RAM_STYLE, "auto", ram_style attribute applied to every bank RAM
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  reset, synchronous, active-high
- wr_data  input  DATA_WIDTH*OUT_CHANNELS  one pixel; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- wr_valid  input  1  wr_data is valid
- wr_ready  output  1  buffer can accept a pixel
- rd_data  output  DATA_WIDTH  current output element (registered)
- rd_valid  output  1  rd_data is valid
- rd_ready  input  1  consumer accepts rd_data
- rd_last  output  1  rd_data is the final element of its frame
- buf_count  output  2  number of complete frames held (0..2)

## Operation
- Storage: 2 banks × OUT_CHANNELS RAMs, each IN_WIDTH*IN_HEIGHT deep (P = IN_WIDTH*IN_HEIGHT). Sync write, sync read.
- State: full[1:0], wr_bank, rd_bank, wr_pix (0..P-1), rd_ch (0..OUT_CHANNELS-1), rd_pix (0..P-1). Counter widths are $clog2 of their range, minimum 1 bit.
- Write side:
  - wr_ready = !rst && !full[wr_bank].
  - On an accepted beat (wr_valid && wr_ready), every channel c writes ram[wr_bank][c][wr_pix], then wr_pix increments.
  - When wr_pix = P-1 is accepted: wr_pix←0, full[wr_bank]←1, wr_bank toggles.
- Read side (advance-when-empty-or-taken):
  - issue = full[rd_bank] && (!rd_valid || rd_ready).
  - On issue: rd_data←ram[rd_bank][rd_ch][rd_pix]; rd_last←(rd_ch=OUT_CHANNELS-1 && rd_pix=P-1); rd_valid←1.
  - Order: rd_pix increments first; on wrap, rd_ch increments.
  - Issuing the last element sets rd_ch←0, rd_pix←0, full[rd_bank]←0 and toggles rd_bank, on the same edge.
  - No issue && rd_ready: rd_valid←0; rd_data and rd_last hold their values.
  - rd_valid && !rd_ready: rd_data, rd_last and rd_valid hold.
- buf_count = full[0] + full[1].
- Simultaneous events:
  - A write completing a frame and a read freeing the other bank on the same edge are both applied.
  - The same bank can never be completed and freed on one edge.
- Full/empty:
  - Both banks full → wr_ready=0 until a bank is freed.
  - Both banks empty → no issue; rd_valid falls after the last element is taken.

## Timing
- Reset values, applied on the first clk edge with rst=1: full=0, wr_bank=rd_bank=0, all counters 0, rd_valid=0, rd_last=0, rd_data=0, buf_count=0. wr_ready=0 while rst=1.
- Reset mid-operation discards all frames, including a partial write and any in-flight read. RAM contents are not cleared.
- Latency: last pixel of a frame accepted on edge k → rd_valid=1 after edge k+1, carrying channel 0 pixel 0.
- Throughput: one write beat per cycle and, with rd_ready held at 1, one read element per cycle. A bank swap costs no bubble on either side.
- Freed bank: writable in the cycle after the edge that issued its last element.

## Test plan
- Reset: drive rst=1 for 2 cycles with random inputs → rd_valid=0, rd_last=0, rd_data=0, buf_count=0, wr_ready=0. After release, wr_ready=1.
- Single frame (5×5×3): write pixel p with channel c = c*32+p, rd_ready=1 → 75 elements in order 0..24, 32..56, 64..88. rd_last=1 only on value 88. rd_valid rises one cycle after the edge accepting the last write.
- Fill both banks, rd_ready=0: write 2 frames → buf_count=2 and wr_ready=0 right after the 50th beat. Then set rd_ready=1 → wr_ready returns to 1 the cycle after the edge issuing frame 1's 75th element.
- Random backpressure (rd_ready 50%): 4 frames with random wr_valid → rd_data is stable whenever rd_valid && !rd_ready; no element lost or duplicated; 300 elements in planar order.
- Concurrency: write frame 2 at full rate while reading frame 1 with rd_ready=1 → wr_ready stays 1 throughout; output is continuous across the frame boundary with no rd_valid gap.
- Mid-read reset: assert rst after 10 elements have been taken → rd_valid=0 and buf_count=0 the next cycle. A new frame written afterwards reads back from channel 0 pixel 0 correctly.
